// File: rtl/rob_pkg.sv
//------------------------------------------------------------------------------
// Module      : rob_pkg
// Description : Shared constants for the reorder buffer. Holds the default
//               buffer/register widths, the entry type codes and the
//               "no dependency" tag helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 3
`endif

`ifndef REG_NUM_WIDTH
`define REG_NUM_WIDTH 5
`endif

package rob_pkg;

  // Entry type codes carried from the decoder into each buffer slot.
  typedef enum logic [1:0] {
    ROB_TYPE_REG    = 2'd0,
    ROB_TYPE_BRANCH = 2'd1,
    ROB_TYPE_STORE  = 2'd2
  } rob_type_e;

  localparam int C_ROB_SIZE_WIDTH_DEF = `ROB_SIZE_WIDTH;
  localparam int C_REG_NUM_WIDTH_DEF  = `REG_NUM_WIDTH;

  // The all-ones tag marks "no dependency"; real tags are zero-extended
  // indices, so their top bit is always clear.
  function automatic logic is_real_tag(input logic top_bit);
    return !top_bit;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rob.sv
//------------------------------------------------------------------------------
// Module      : rob
// Description : Circular reorder buffer. Entries are issued in order at the
//               tail, completed out of order through the result bus, and
//               retired in order from the head, one per cycle. A retiring
//               mispredicted branch raises a one-cycle flush pulse and the
//               whole buffer is emptied on the following cycle.
// Ports       : clk_in/rst_in/rdy_in          clock, async reset, enable
//               dec_*                         issue request from decoder
//               cdb_*                         result broadcast
//               full_out, new_dependency_out  issue status / next tag
//               commit_*                      register retirement pulse
//               store_commit                  store retirement pulse
//               need_flush_out, flush_pc_out  mispredict redirect
//               commit_cnt_out                retired-entry counter
//                                             (only with ROB_COMMIT_CNT_EN)
// Options     : define ROB_COMMIT_CNT_EN to add the retired-entry counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rob
  import rob_pkg::*;
#(
  parameter int ROB_SIZE_WIDTH = `ROB_SIZE_WIDTH,
  parameter int REG_NUM_WIDTH  = `REG_NUM_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      dec_valid,
  input  logic [1:0]                dec_type,
  input  logic [REG_NUM_WIDTH-1:0]  dec_rd,
  input  logic                      dec_pred_taken,
  input  logic [31:0]               dec_alt_pc,
  input  logic                      cdb_valid,
  input  logic [ROB_SIZE_WIDTH:0]   cdb_tag,
  input  logic [31:0]               cdb_value,
`ifdef ROB_COMMIT_CNT_EN
  output logic [31:0]               commit_cnt_out,
`endif
  output logic                      full_out,
  output logic [ROB_SIZE_WIDTH:0]   new_dependency_out,
  output logic                      commit_valid,
  output logic [REG_NUM_WIDTH-1:0]  commit_rd,
  output logic [31:0]               commit_value,
  output logic [ROB_SIZE_WIDTH:0]   commit_dependency,
  output logic                      store_commit,
  output logic                      need_flush_out,
  output logic [31:0]               flush_pc_out
);

  localparam int DEPTH = 2 ** ROB_SIZE_WIDTH;
  localparam int TAG_W = ROB_SIZE_WIDTH + 1;

  typedef logic [ROB_SIZE_WIDTH-1:0] ptr_t;

  // Control state (reset)
  ptr_t               head_q, head_d;
  ptr_t               tail_q, tail_d;
  logic [TAG_W-1:0]   count_q, count_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [DEPTH-1:0]   ready_q, ready_d;

  // Output registers (reset)
  logic                     commit_valid_q, commit_valid_d;
  logic                     store_commit_q, store_commit_d;
  logic                     need_flush_q, need_flush_d;
  logic [REG_NUM_WIDTH-1:0] commit_rd_q, commit_rd_d;
  logic [31:0]              commit_value_q, commit_value_d;
  logic [TAG_W-1:0]         commit_dep_q, commit_dep_d;
  logic [31:0]              flush_pc_q, flush_pc_d;

  // Entry payload (no reset; qualified by valid_q)
  rob_type_e                type_q   [DEPTH];
  logic [REG_NUM_WIDTH-1:0] rd_q     [DEPTH];
  logic [31:0]              alt_pc_q [DEPTH];
  logic [31:0]              value_q  [DEPTH];
  logic [DEPTH-1:0]         pred_q;

  ptr_t w_wb_idx;
  logic w_issue;
  logic w_wb;
  logic w_commit;
  logic w_mispredict;

  assign full_out           = (count_q == TAG_W'(DEPTH));
  assign new_dependency_out = {1'b0, tail_q};

  assign w_wb_idx = cdb_tag[ROB_SIZE_WIDTH-1:0];

  // Nothing new is accepted during the flush cycle; the buffer is about to
  // be emptied regardless.
  assign w_issue  = dec_valid && !full_out && !need_flush_q;
  assign w_wb     = cdb_valid && is_real_tag(cdb_tag[ROB_SIZE_WIDTH])
                    && valid_q[w_wb_idx] && !need_flush_q;
  // ready_q is the registered flag, so a result written back this cycle
  // cannot retire before the next cycle.
  assign w_commit = valid_q[head_q] && ready_q[head_q] && !need_flush_q;

  assign w_mispredict = (type_q[head_q] == ROB_TYPE_BRANCH)
                        && (value_q[head_q][0] != pred_q[head_q]);

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    valid_d        = valid_q;
    ready_d        = ready_q;
    commit_valid_d = 1'b0;
    store_commit_d = 1'b0;
    need_flush_d   = 1'b0;
    commit_rd_d    = commit_rd_q;
    commit_value_d = commit_value_q;
    commit_dep_d   = commit_dep_q;
    flush_pc_d     = flush_pc_q;

    if (need_flush_q) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
      ready_d = '0;
    end else begin
      if (w_wb) begin
        ready_d[w_wb_idx] = 1'b1;
      end

      if (w_commit) begin
        valid_d[head_q] = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
        case (type_q[head_q])
          ROB_TYPE_REG: begin
            commit_valid_d = 1'b1;
            commit_rd_d    = rd_q[head_q];
            commit_value_d = value_q[head_q];
            commit_dep_d   = {1'b0, head_q};
          end
          ROB_TYPE_STORE: begin
            store_commit_d = 1'b1;
          end
          ROB_TYPE_BRANCH: begin
            if (w_mispredict) begin
              need_flush_d = 1'b1;
              flush_pc_d   = alt_pc_q[head_q];
            end
          end
          default: ;
        endcase
      end

      // Issue uses the pre-commit full flag, so a slot freed this cycle is
      // not reusable until the next one.
      if (w_issue) begin
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = 1'b0;
        tail_d          = tail_q + 1'b1;
      end

      count_d = count_q + TAG_W'(w_issue) - TAG_W'(w_commit);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      ready_q        <= '0;
      commit_valid_q <= 1'b0;
      store_commit_q <= 1'b0;
      need_flush_q   <= 1'b0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
      commit_dep_q   <= '1;
      flush_pc_q     <= '0;
    end else if (rdy_in) begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      valid_q        <= valid_d;
      ready_q        <= ready_d;
      commit_valid_q <= commit_valid_d;
      store_commit_q <= store_commit_d;
      need_flush_q   <= need_flush_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
      commit_dep_q   <= commit_dep_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (w_issue) begin
        type_q[tail_q]   <= rob_type_e'(dec_type);
        rd_q[tail_q]     <= dec_rd;
        pred_q[tail_q]   <= dec_pred_taken;
        alt_pc_q[tail_q] <= dec_alt_pc;
      end
      if (w_wb) begin
        value_q[w_wb_idx] <= cdb_value;
      end
    end
  end

  // Pulse registers hold while stalled; masking with rdy_in keeps them
  // invisible until the stall ends, so each pulse is seen exactly once.
  assign commit_valid      = commit_valid_q && rdy_in;
  assign store_commit      = store_commit_q && rdy_in;
  assign need_flush_out    = need_flush_q && rdy_in;
  assign commit_rd         = commit_rd_q;
  assign commit_value      = commit_value_q;
  assign commit_dependency = commit_dep_q;
  assign flush_pc_out      = flush_pc_q;

`ifdef ROB_COMMIT_CNT_EN
  logic [31:0] commit_cnt_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      commit_cnt_q <= '0;
    end else if (rdy_in && w_commit) begin
      commit_cnt_q <= commit_cnt_q + 32'd1;
    end
  end

  assign commit_cnt_out = commit_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rob.sv
//------------------------------------------------------------------------------
// Module      : tb_rob
// Description : Self-checking bench for rob. A queue-based model of the
//               buffer predicts every output each cycle; directed sequences
//               add hand-computed literal expectations.
// Ports       : none (testbench)
// Options     : ROB_COMMIT_CNT_EN also checks the retired-entry counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rob;
  import rob_pkg::*;

  localparam int DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        dec_valid = 1'b0;
  logic [1:0]  dec_type = 2'd0;
  logic [4:0]  dec_rd = 5'd0;
  logic        dec_pred_taken = 1'b0;
  logic [31:0] dec_alt_pc = 32'd0;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_tag = 4'd0;
  logic [31:0] cdb_value = 32'd0;

  logic        full_out;
  logic [3:0]  new_dependency_out;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [3:0]  commit_dependency;
  logic        store_commit;
  logic        need_flush_out;
  logic [31:0] flush_pc_out;
`ifdef ROB_COMMIT_CNT_EN
  logic [31:0] commit_cnt_out;
`endif

  rob dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .dec_valid          (dec_valid),
    .dec_type           (dec_type),
    .dec_rd             (dec_rd),
    .dec_pred_taken     (dec_pred_taken),
    .dec_alt_pc         (dec_alt_pc),
    .cdb_valid          (cdb_valid),
    .cdb_tag            (cdb_tag),
    .cdb_value          (cdb_value),
`ifdef ROB_COMMIT_CNT_EN
    .commit_cnt_out     (commit_cnt_out),
`endif
    .full_out           (full_out),
    .new_dependency_out (new_dependency_out),
    .commit_valid       (commit_valid),
    .commit_rd          (commit_rd),
    .commit_value       (commit_value),
    .commit_dependency  (commit_dependency),
    .store_commit       (store_commit),
    .need_flush_out     (need_flush_out),
    .flush_pc_out       (flush_pc_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] alt;
    logic        ready;
    logic [31:0] val;
    int          tag;
  } ment_t;

  ment_t       mq[$];
  int          m_tail;
  bit          e_cv, e_sc, e_nf;
  logic [4:0]  e_rd;
  logic [31:0] e_val, e_pc;
  logic [3:0]  e_dep;
  int          e_cnt;

  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    e_cv = 0; e_sc = 0; e_nf = 0;
    e_rd = '0; e_val = '0; e_pc = '0; e_dep = 4'hF;
    e_cnt = 0;
  endtask

  task automatic model_step();
    ment_t h;
    ment_t n;
    bit was_full;
    if (e_nf) begin
      mq.delete();
      m_tail = 0;
      e_cv = 0; e_sc = 0; e_nf = 0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    e_cv = 0; e_sc = 0; e_nf = 0;
    // Retirement sees readiness from earlier cycles only.
    if (mq.size() > 0 && mq[0].ready) begin
      h = mq.pop_front();
      e_cnt++;
      if (h.typ == 2'd0) begin
        e_cv = 1; e_rd = h.rd; e_val = h.val; e_dep = 4'(h.tag);
      end else if (h.typ == 2'd2) begin
        e_sc = 1;
      end else if (h.typ == 2'd1 && h.val[0] != h.pred) begin
        e_nf = 1; e_pc = h.alt;
      end
    end
    if (cdb_valid) begin
      foreach (mq[i]) begin
        if (mq[i].tag == int'(cdb_tag)) begin
          mq[i].ready = 1;
          mq[i].val   = cdb_value;
        end
      end
    end
    if (dec_valid && !was_full) begin
      n.typ = dec_type; n.rd = dec_rd; n.pred = dec_pred_taken; n.alt = dec_alt_pc;
      n.ready = 0; n.val = '0; n.tag = m_tail;
      mq.push_back(n);
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_in or posedge rst_in);
      if (rst_in) model_reset();
      else if (rdy_in) model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk_in);
      check("full_out", 32'(full_out), 32'(mq.size() == DEPTH));
      check("new_dependency_out", 32'(new_dependency_out), 32'(m_tail));
      check("commit_valid", 32'(commit_valid), 32'(e_cv && rdy_in));
      check("store_commit", 32'(store_commit), 32'(e_sc && rdy_in));
      check("need_flush_out", 32'(need_flush_out), 32'(e_nf && rdy_in));
      check("commit_rd", 32'(commit_rd), 32'(e_rd));
      check("commit_value", commit_value, e_val);
      check("commit_dependency", 32'(commit_dependency), 32'(e_dep));
      check("flush_pc_out", flush_pc_out, e_pc);
`ifdef ROB_COMMIT_CNT_EN
      check("commit_cnt_out", commit_cnt_out, 32'(e_cnt));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_in);
    #2;
    dec_valid = 1'b0;
    cdb_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd, input logic pred, input logic [31:0] alt);
    dec_valid = 1'b1; dec_type = t; dec_rd = rd; dec_pred_taken = pred; dec_alt_pc = alt;
  endtask

  task automatic wb(input logic [3:0] tag, input logic [31:0] v);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = v;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step();
    step();
    rst_in = 1'b0;
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    step();
    step();
    check("reset_full", 32'(full_out), 32'd0);
    check("reset_new_dep", 32'(new_dependency_out), 32'd0);
    check("reset_commit_valid", 32'(commit_valid), 32'd0);
    check("reset_commit_dep", 32'(commit_dependency), 32'hF);
    rst_in = 1'b0;

    // Single REG instruction round trip.
    issue(ROB_TYPE_REG, 5'd5, 1'b0, 32'd0); step();
    wb(4'd0, 32'h1234); step();
    check("t1_no_early_commit", 32'(commit_valid), 32'd0);
    step();
    check("t1_commit_valid", 32'(commit_valid), 32'd1);
    check("t1_commit_rd", 32'(commit_rd), 32'd5);
    check("t1_commit_value", commit_value, 32'h1234);
    check("t1_commit_dep", 32'(commit_dependency), 32'd0);
    step();
    check("t1_pulse_ends", 32'(commit_valid), 32'd0);

    // Fill to full; blocked issue; commit does not unblock same cycle.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      issue(ROB_TYPE_REG, 5'(i + 1), 1'b0, 32'd0); step();
    end
    check("t2_full", 32'(full_out), 32'd1);
    check("t2_tail_wrapped", 32'(new_dependency_out), 32'd0);
    issue(ROB_TYPE_REG, 5'd20, 1'b0, 32'd0); step();
    check("t2_ninth_ignored", 32'(new_dependency_out), 32'd0);
    wb(4'd0, 32'hA); step();
    issue(ROB_TYPE_REG, 5'd21, 1'b0, 32'd0); step();
    check("t2_commit_rd", 32'(commit_rd), 32'd1);
    check("t2_blocked_full", 32'(full_out), 32'd0);
    check("t2_blocked_tail", 32'(new_dependency_out), 32'd0);
    issue(ROB_TYPE_REG, 5'd22, 1'b0, 32'd0); step();
    check("t2_refilled", 32'(full_out), 32'd1);
    check("t2_tail_one", 32'(new_dependency_out), 32'd1);
    #1 rst_in = 1'b1;
    #1 check("t2_async_reset_full", 32'(full_out), 32'd0);
    check("t2_async_reset_tail", 32'(new_dependency_out), 32'd0);
    step();
    rst_in = 1'b0;

    // Out-of-order completion, in-order retirement.
    do_reset();
    issue(ROB_TYPE_REG, 5'd10, 1'b0, 32'd0); step();
    issue(ROB_TYPE_REG, 5'd11, 1'b0, 32'd0); step();
    issue(ROB_TYPE_REG, 5'd12, 1'b0, 32'd0); step();
    wb(4'd2, 32'h22); step();
    wb(4'd1, 32'h11); step();
    wb(4'd0, 32'h10); step();
    step();
    check("t3_dep0", 32'(commit_dependency), 32'd0);
    check("t3_val0", commit_value, 32'h10);
    issue(ROB_TYPE_STORE, 5'd0, 1'b0, 32'd0); step();
    check("t3_dep1", 32'(commit_dependency), 32'd1);
    check("t3_val1", commit_value, 32'h11);
    check("t3_tail_after_issue", 32'(new_dependency_out), 32'd4);
    step();
    check("t3_dep2", 32'(commit_dependency), 32'd2);
    check("t3_rd2", 32'(commit_rd), 32'd12);
    step();

    // Mispredicted branch triggers a flush; flush-cycle traffic is dropped.
    do_reset();
    issue(ROB_TYPE_BRANCH, 5'd0, 1'b1, 32'h100); step();
    issue(ROB_TYPE_REG, 5'd3, 1'b0, 32'd0); step();
    wb(4'd0, 32'd0); step();
    step();
    check("t4_need_flush", 32'(need_flush_out), 32'd1);
    check("t4_flush_pc", flush_pc_out, 32'h100);
    issue(ROB_TYPE_REG, 5'd4, 1'b0, 32'd0);
    wb(4'd1, 32'd5);
    step();
    check("t4_flush_done", 32'(need_flush_out), 32'd0);
    check("t4_empty_tail", 32'(new_dependency_out), 32'd0);
    check("t4_not_full", 32'(full_out), 32'd0);
    step();
    step();
    check("t4_nothing_left", 32'(commit_valid), 32'd0);

    // Correct branch, store, REG to r0.
    do_reset();
    issue(ROB_TYPE_BRANCH, 5'd0, 1'b0, 32'h200); step();
    issue(ROB_TYPE_STORE, 5'd0, 1'b0, 32'd0); step();
    issue(ROB_TYPE_REG, 5'd0, 1'b0, 32'd0); step();
    wb(4'd0, 32'h0); step();
    wb(4'd1, 32'hDEAD); step();
    check("t5_branch_silent", 32'(need_flush_out), 32'd0);
    wb(4'd2, 32'h77); step();
    check("t5_store_commit", 32'(store_commit), 32'd1);
    step();
    check("t5_r0_commit", 32'(commit_valid), 32'd1);
    check("t5_r0_value", commit_value, 32'h77);
`ifdef ROB_COMMIT_CNT_EN
    check("t5_commit_cnt", commit_cnt_out, 32'd3);
`endif
    step();

    // Stall with rdy_in low, then reset in the middle of a commit pulse.
    do_reset();
    issue(ROB_TYPE_REG, 5'd7, 1'b0, 32'd0); step();
    wb(4'd0, 32'h55); step();
    rdy_in = 1'b0;
    issue(ROB_TYPE_REG, 5'd8, 1'b0, 32'd0); step();
    check("t6_stall_no_commit", 32'(commit_valid), 32'd0);
    check("t6_stall_tail", 32'(new_dependency_out), 32'd1);
    step();
    rdy_in = 1'b1;
    step();
    check("t6_commit_after_stall", 32'(commit_valid), 32'd1);
    check("t6_commit_value", commit_value, 32'h55);
    #1 rst_in = 1'b1;
    #1 check("t6_reset_commit_valid", 32'(commit_valid), 32'd0);
    check("t6_reset_commit_dep", 32'(commit_dependency), 32'hF);
    check("t6_reset_commit_value", commit_value, 32'd0);
    step();
    rst_in = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameter ROB_SIZE_WIDTH, default `ROB_SIZE_WIDTH (3), log2 of entry count; depth = 2**ROB_SIZE_WIDTH.
REQ-002 Parameter REG_NUM_WIDTH, default `REG_NUM_WIDTH (5), architectural register index width.
REQ-003 clk_in  input  1  single clock, all state on rising edge.
REQ-004 rst_in  input  1  reset, asynchronous, active-high.
REQ-005 rdy_in  input  1  global enable; low freezes all state.
REQ-006 dec_valid  input  1  decoder issues one instruction this cycle.
REQ-007 dec_type  input  2  entry type: REG=0, BRANCH=1, STORE=2.
REQ-008 dec_rd  input  REG_NUM_WIDTH  destination register (REG type).
REQ-009 dec_pred_taken  input  1  predicted direction (BRANCH type).
REQ-010 dec_alt_pc  input  32  recovery PC if prediction wrong.
REQ-011 cdb_valid  input  1  execution result broadcast.
REQ-012 cdb_tag  input  ROB_SIZE_WIDTH+1  entry the result belongs to.
REQ-013 cdb_value  input  32  result value / actual branch taken in bit 0.
REQ-014 full_out  output  1  no free entry; decoder must not issue.
REQ-015 new_dependency_out  output  ROB_SIZE_WIDTH+1  tag the next issued entry receives (combinational, {0,tail}).
REQ-016 commit_valid  output  1  one-cycle register-commit pulse.
REQ-017 commit_rd  output  REG_NUM_WIDTH  register written.
REQ-018 commit_value  output  32  value written.
REQ-019 commit_dependency  output  ROB_SIZE_WIDTH+1  tag of committing entry.
REQ-020 store_commit  output  1  one-cycle pulse: head store may write memory.
REQ-021 need_flush_out  output  1  one-cycle mispredict flush pulse.
REQ-022 flush_pc_out  output  32  redirect PC, valid with need_flush_out.

Function
REQ-023 Circular buffer with head, tail pointers and an occupancy count (ROB_SIZE_WIDTH+1 bits); full_out = (count == depth), registered-state only.
REQ-024 Issue: dec_valid && !full_out && !need_flush_out writes entry[tail] with ready=0, tail wraps depth-1 -> 0, count+1.
REQ-025 Tag value all-ones means "no dependency"; valid tags are zero-extended indices.
REQ-026 Writeback: cdb_valid sets entry[cdb_tag].ready=1 and stores cdb_value; writeback to an empty entry is ignored.
REQ-027 Commit: at most one per cycle, head entry only, only when ready was set in a previous cycle (writeback-to-commit latency >= 1 cycle).
REQ-028 REG commit: commit_valid=1 next cycle with rd, value, tag=head; rd==0 still pulses commit_valid.
REQ-029 STORE commit: store_commit=1 for one cycle; no register output.
REQ-030 BRANCH commit: if cdb bit0 != pred_taken, need_flush_out=1, flush_pc_out=alt_pc; else retire silently.
REQ-031 Flush: the cycle after need_flush_out is raised, head=tail=count=0, all ready cleared; issue and writeback in the flush cycle are discarded.
REQ-032 Simultaneous issue and commit: count unchanged; issue while full is blocked even if commit frees an entry that cycle.
REQ-033 Simultaneous writeback and issue to the same index cannot occur (entry not free); no priority required.
REQ-034 rdy_in low: no pointer or entry change; all pulse outputs deasserted.

Reset
REQ-035 rst_in high asynchronously clears head, tail, count, all ready bits, commit_valid, store_commit, need_flush_out to 0; commit_dependency to all-ones; commit_rd, commit_value, flush_pc_out to 0.

Configuration
REQ-036 ROB_COMMIT_CNT_EN defined: extra output commit_cnt_out (32) counts retired entries of all types, cleared only by reset, wraps at 2**32.
REQ-037 ROB_COMMIT_CNT_EN undefined: no counter logic, no port.

Structure
REQ-038 Type codes, ROB_SIZE_WIDTH, REG_NUM_WIDTH and the all-ones no-dependency tag live in the shared const_param include.
REQ-039 Single module; no sub-module needed.

Verification
REQ-040 Issue REG rd=5, cdb tag 0 value 0x1234 -> next-next cycle commit_valid=1, rd=5, value=0x1234, dependency=0.
REQ-041 Issue 8 entries with no writeback -> full_out=1, 9th dec_valid ignored, tail stays 0.
REQ-042 BRANCH pred_taken=1, cdb bit0=0, alt_pc=0x100 -> need_flush_out=1, flush_pc_out=0x100; following cycle count=0, new_dependency_out=0.
REQ-043 Writebacks out of order (tag 2, 1, 0) -> commits emitted in order 0, 1, 2 on consecutive cycles.
REQ-044 Assert rst_in mid-commit between clock edges -> outputs cleared immediately, full_out=0.
REQ-045 With ROB_COMMIT_CNT_EN, 3 commits of mixed type -> commit_cnt_out=3.
